ifetch_queue: RTL
=================

# ifetch_queue

Instruction prefetch stage that sits directly upstream of the f8 core's instruction read port. It fetches little-endian 16-bit words from program memory through a req/gnt/rvalid handshake and holds them in a small byte queue. It presents the core with a 24-bit instruction window starting at any byte address, raising valid only when all three bytes are present. When the core requests an address outside the queued bytes, which happens on jumps, calls and relative branches, the queue flushes and refetches from the new target.

## Interface
- QUEUE_BYTES, 6: byte capacity of the queue. Must be even and at least 4.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cpu_addr  in  16  byte address of the requested instruction window; driven by the core's iread_addr.
- cpu_data  out  24  bytes [cpu_addr+2, cpu_addr+1, cpu_addr] in bits [23:16], [15:8], [7:0]; the opcode is in [7:0].
- cpu_valid  out  1  cpu_data holds all three bytes this cycle.
- mem_req  out  1  word read request.
- mem_addr  out  16  byte address of the requested word; bit 0 is always 0.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata  in  16  returned word; the byte at mem_addr is in [7:0], the byte at mem_addr+1 is in [15:8].
- mem_rvalid  in  1  mem_rdata valid this cycle.

## Operation
- State:
  - q_base (16 bits): byte address of queue entry 0.
  - q_cnt (0..QUEUE_BYTES): number of queued bytes.
  - fetch_addr (16 bits, even): address of the next word to fetch.
  - skip_lo: drop the low byte of the next accepted word.
  - pending: one request granted, response not yet received.
  - stale: the pending response must be discarded.
- Combinational window logic:
  - off = cpu_addr - q_base, computed modulo 2^16.
  - in_q = (off <= q_cnt).
  - cpu_valid = !reset && (q_cnt >= 3) && (off <= q_cnt - 3).
  - cpu_data = queue[off+2], queue[off+1], queue[off] when valid; X otherwise.
- Each clock edge, when not in reset:
  - If in_q: drop off bytes from the front, set q_base <= cpu_addr, q_cnt <= q_cnt - off. This covers both consumption and holding (off = 0).
  - If !in_q (flush):
    - Set q_cnt <= 0 and q_base <= cpu_addr.
    - Set fetch_addr <= {cpu_addr[15:1], 1'b0} and skip_lo <= cpu_addr[0].
    - If pending, set stale <= 1.
    - Any request that was not granted is withdrawn.
- Request rules:
  - mem_req = !reset && !pending && !flush_this_cycle && (q_cnt_after_drop + 2 <= QUEUE_BYTES).
  - mem_addr = fetch_addr.
  - mem_req and mem_addr stay stable until mem_gnt, except on flush.
  - At most one request is outstanding.
  - On mem_gnt: set pending <= 1 and fetch_addr <= fetch_addr + 2, modulo 2^16.
- Response rules, on mem_rvalid with pending:
  - Clear pending.
  - If stale: clear stale and discard the data.
  - Otherwise append mem_rdata at q_cnt_after_drop. If skip_lo is set, append only [15:8] and clear skip_lo.
  - Ignore mem_rvalid when pending = 0.
- Simultaneous events within one cycle:
  - Drop is applied first, then append. Both update q_cnt in the same edge.
  - Flush plus rvalid in the same cycle discards the data; stale is not set because pending clears.
  - Overflow is impossible by the request rule. Assert q_cnt <= QUEUE_BYTES in simulation.
- Wrap-around: all address arithmetic is modulo 2^16. A window at 0xFFFE holds bytes 0xFFFE, 0xFFFF, 0x0000.

## Timing
- Reset values: cpu_valid 0, mem_req 0, q_cnt 0, q_base 0, fetch_addr 0, pending 0, stale 0, skip_lo 0.
- Releasing reset with cpu_addr = 0x4000 (core reset PC) is treated as a flush on the first non-reset edge.
- cpu_valid and cpu_data are combinational from cpu_addr and the registered state. There is no register between the two.
- Memory contract:
  - mem_gnt may be asserted in the same cycle as mem_req.
  - mem_rvalid arrives at least 1 cycle after the grant.
- Flush latency with zero-wait memory (gnt same cycle, rvalid next cycle): cpu_valid asserts in the cycle after the 4th edge following the flush edge. This holds for both even and odd targets.
- Reset asserted mid-fetch: all state clears at that edge. A late mem_rvalid after reset is ignored because pending = 0.
- A core holding cpu_addr while cpu_valid = 0 stalls. The queue never drops bytes at or after cpu_addr.

## Test plan
- Reset, then cpu_addr = 0x4000, memory words 0x4000→0x2211, 0x4002→0x4433, zero-wait → cpu_valid rises after 4 edges with cpu_data = 0x332211; advancing cpu_addr to 0x4001 → 0x443322 with no refetch.
- Sequential stream of 1-, 2- and 3-byte steps from 0x4000 → cpu_data always matches the memory model; mem_addr increments by 2; q_cnt never exceeds 6.
- Jump from 0x4000 to 0x5001 while a 3-cycle-latency request is pending → stale word is discarded; first appended byte is from 0x5001; cpu_data = {m[0x5003], m[0x5002], m[0x5001]}.
- cpu_addr = 0xFFFE → mem_addr sequence 0xFFFE, 0x0000; cpu_data = {m[0x0000], m[0xFFFF], m[0xFFFE]}.
- mem_gnt held low for 5 cycles → mem_req and mem_addr stay stable throughout; cpu_valid stays 0; no spurious append.
- reset pulsed 1 cycle after mem_gnt, followed by a late mem_rvalid → data is ignored; q_cnt = 0; refetch starts at {cpu_addr[15:1], 0}.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Purpose: bundles the core-side instruction window and the memory-side word fetch handshake.
// Latency: none, wires only.
// Backpressure: req is held until gnt; the window is qualified by cpu_valid.
//
// Ports:
//   cpu_addr/cpu_data/cpu_valid : core instruction read port (24-bit window at a byte address)
//   mem_req/mem_addr/mem_gnt    : word read request channel, 16-bit even byte address
//   mem_rdata/mem_rvalid        : word response channel, little-endian
interface ifetch_queue_if;
  logic [15:0] cpu_addr;
  logic [23:0] cpu_data;
  logic        cpu_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  // master: the prefetch queue itself
  modport master (
    input  cpu_addr,
    output cpu_data,
    output cpu_valid,
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata,
    input  mem_rvalid
  );

  // slave: the core plus program memory around the queue
  modport slave (
    output cpu_addr,
    input  cpu_data,
    input  cpu_valid,
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/ifetch_queue.sv
// Purpose: instruction prefetch byte queue presenting a 24-bit window at any byte address.
// Latency: window is combinational from cpu_addr; flush-to-valid is 4 edges with zero-wait memory.
// Backpressure: core stalls on cpu_valid=0; mem_req held until mem_gnt, one request outstanding.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : ifetch_queue_if.master (core window + memory req/gnt/rvalid)
module ifetch_queue #(
  parameter int QUEUE_BYTES = 6
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(QUEUE_BYTES + 1);

  logic [7:0]    q  [QUEUE_BYTES];
  logic [7:0]    nq [QUEUE_BYTES];
  logic [15:0]   q_base;
  logic [CW-1:0] q_cnt;
  logic [15:0]   fetch_addr;
  logic          skip_lo;
  logic          pending;
  logic          stale;

  logic [15:0]   off;
  logic [15:0]   cnt16;
  logic          in_q;
  logic          flush;
  logic [CW-1:0] off_c;
  logic [CW-1:0] cnt_drop;
  logic          accept;
  logic [1:0]    n_app;
  logic [CW-1:0] nq_cnt;

  // Window position and drop amount for this cycle.
  always_comb begin
    off      = bus.cpu_addr - q_base;
    cnt16    = 16'(q_cnt);
    in_q     = (off <= cnt16);
    flush    = !in_q;
    // off fits in CW bits whenever in_q holds, since off <= q_cnt.
    off_c    = in_q ? off[CW-1:0] : '0;
    cnt_drop = in_q ? (q_cnt - off_c) : '0;
  end

  // A response is only kept if it belongs to the current fetch stream;
  // a flush in the same cycle kills it just as stale does.
  always_comb begin
    accept = !reset && pending && bus.mem_rvalid && !stale && !flush;
    n_app  = 2'd0;
    if (accept) begin
      n_app = skip_lo ? 2'd1 : 2'd2;
    end
    nq_cnt = cnt_drop + CW'(n_app);
  end

  // Next queue contents: shift left by off_c, then append at cnt_drop.
  // Loops use constant indices only so no dynamic array indexing is needed.
  always_comb begin
    for (int i = 0; i < QUEUE_BYTES; i++) begin
      nq[i] = q[i];
      for (int j = 0; j < QUEUE_BYTES; j++) begin
        if (j == i + int'(off_c)) begin
          nq[i] = q[j];
        end
      end
      if (n_app == 2'd2) begin
        if (i == int'(cnt_drop))     nq[i] = bus.mem_rdata[7:0];
        if (i == int'(cnt_drop) + 1) nq[i] = bus.mem_rdata[15:8];
      end else if (n_app == 2'd1) begin
        if (i == int'(cnt_drop))     nq[i] = bus.mem_rdata[15:8];
      end
    end
  end

  // Core-side window.
  always_comb begin
    bus.cpu_valid = !reset && (cnt16 >= 16'd3) && (off <= cnt16 - 16'd3);
    bus.cpu_data  = 'x;
    if (bus.cpu_valid) begin
      for (int i = 0; i + 2 < QUEUE_BYTES; i++) begin
        if (off == 16'(i)) begin
          bus.cpu_data = {q[i+2], q[i+1], q[i]};
        end
      end
    end
  end

  // Request only when the post-drop queue has room for a whole word, so
  // an append can never overflow. Nothing is requested in a flush cycle.
  always_comb begin
    bus.mem_req  = !reset && !pending && !flush &&
                   (16'(cnt_drop) + 16'd2 <= 16'(QUEUE_BYTES));
    bus.mem_addr = fetch_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_base     <= '0;
      q_cnt      <= '0;
      fetch_addr <= '0;
      skip_lo    <= 1'b0;
      pending    <= 1'b0;
      stale      <= 1'b0;
      for (int i = 0; i < QUEUE_BYTES; i++) q[i] <= '0;
    end else begin
      q_base <= bus.cpu_addr;
      q_cnt  <= nq_cnt;
      for (int i = 0; i < QUEUE_BYTES; i++) q[i] <= nq[i];

      if (flush) begin
        fetch_addr <= {bus.cpu_addr[15:1], 1'b0};
        skip_lo    <= bus.cpu_addr[0];
        // A response landing this very edge is dropped and retires the
        // request; otherwise the in-flight one must be discarded later.
        if (pending && bus.mem_rvalid) begin
          pending <= 1'b0;
          stale   <= 1'b0;
        end else begin
          stale   <= pending;
        end
      end else begin
        if (bus.mem_req && bus.mem_gnt) begin
          pending    <= 1'b1;
          fetch_addr <= fetch_addr + 16'd2;
        end
        if (pending && bus.mem_rvalid) begin
          pending <= 1'b0;
          if (stale) begin
            stale <= 1'b0;
          end else if (skip_lo) begin
            skip_lo <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (16'(q_cnt) <= 16'(QUEUE_BYTES));
    end
  end

endmodule
